// File: rtl/decode_unit_pkg.sv
// Shared types for the decode stage: fetch/rename packs, decoded op enums,
// feedback structs and exception ids.
package decode_unit_pkg;

  localparam int DECODE_WIDTH = 4;

  typedef enum logic [4:0] {
    EXC_INSTR_MISALIGNED    = 5'd0,
    EXC_INSTR_ACCESS_FAULT  = 5'd1,
    EXC_ILLEGAL_INSTRUCTION = 5'd2,
    EXC_BREAKPOINT          = 5'd3,
    EXC_LOAD_MISALIGNED     = 5'd4,
    EXC_LOAD_ACCESS_FAULT   = 5'd5,
    EXC_STORE_MISALIGNED    = 5'd6,
    EXC_STORE_ACCESS_FAULT  = 5'd7,
    EXC_ECALL_M             = 5'd11
  } riscv_exception_t;

  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  typedef enum logic [2:0] {
    OP_UNIT_ALU, OP_UNIT_BRU, OP_UNIT_CSR, OP_UNIT_DIV, OP_UNIT_LSU, OP_UNIT_MUL
  } op_unit_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    BRU_JAL, BRU_JALR, BRU_BEQ, BRU_BNE, BRU_BLT, BRU_BGE, BRU_BLTU, BRU_BGEU
  } bru_op_t;

  typedef enum logic [2:0] {
    LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsu_op_t;

  typedef enum logic [2:0] {
    CSR_RW, CSR_RS, CSR_RC, CSR_ECALL, CSR_EBREAK, CSR_MRET, CSR_WFI
  } csr_op_t;

  typedef enum logic [1:0] {MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU} mul_op_t;
  typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    bru_op_t bru_op;
    lsu_op_t lsu_op;
    csr_op_t csr_op;
    mul_op_t mul_op;
    div_op_t div_op;
  } sub_op_t;

  typedef enum logic [1:0] {ARG_SRC_REG, ARG_SRC_IMM, ARG_SRC_DISABLE} arg_src_t;

  typedef struct packed {
    logic [31:0]      value;
    logic [31:0]      pc;
    logic             has_exception;
    riscv_exception_t exception_id;
    logic [31:0]      exception_value;
  } fetch_decode_pack_t;

  typedef struct packed {
    logic [31:0]      value;
    logic [31:0]      pc;
    op_t              op;
    op_unit_t         op_unit;
    sub_op_t          sub_op;
    logic [31:0]      imm;
    arg_src_t         arg1_src;
    arg_src_t         arg2_src;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             rd_enable;
    logic [11:0]      csr;
    logic             has_exception;
    riscv_exception_t exception_id;
    logic [31:0]      exception_value;
  } decode_rename_pack_t;

  typedef struct packed {
    logic idle;
  } decode_feedback_pack_t;

  typedef struct packed {
    logic       enable;
    logic       flush;
    logic [2:0] committed_num;
  } commit_feedback_pack_t;

endpackage

// File: rtl/decode_unit_decode_one.sv
// Single-instruction combinational decoder for RV32IM + Zicsr + system ops.
module decode_one
  import decode_unit_pkg::*;
(
  input  fetch_decode_pack_t  fd_in,
  output decode_rename_pack_t dr_out
);

  logic [31:0] v;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic        legal;
  logic        has_rd;
  op_t         op;
  op_unit_t    op_unit;
  sub_op_t     sub_op;
  logic [31:0] imm;
  arg_src_t    arg1_src;
  arg_src_t    arg2_src;

  assign v      = fd_in.value;
  assign opcode = v[6:0];
  assign funct3 = v[14:12];
  assign funct7 = v[31:25];
  assign imm_i  = {{20{v[31]}}, v[31:20]};
  assign imm_s  = {{20{v[31]}}, v[31:25], v[11:7]};
  assign imm_b  = {{19{v[31]}}, v[31], v[7], v[30:25], v[11:8], 1'b0};
  assign imm_u  = {v[31:12], 12'b0};
  assign imm_j  = {{11{v[31]}}, v[31], v[19:12], v[20], v[30:21], 1'b0};
  assign imm_z  = {27'b0, v[19:15]};

  always_comb begin
    legal    = 1'b0;
    has_rd   = 1'b0;
    op       = OP_NOP;
    op_unit  = OP_UNIT_ALU;
    sub_op   = '0;
    imm      = '0;
    arg1_src = ARG_SRC_DISABLE;
    arg2_src = ARG_SRC_DISABLE;
    case (opcode)
      7'b0110111: begin
        legal = 1'b1; has_rd = 1'b1; op = OP_LUI; imm = imm_u; arg2_src = ARG_SRC_IMM;
      end
      // auipc adds pc in the ALU; arg1 is implied by op, not a register
      7'b0010111: begin
        legal = 1'b1; has_rd = 1'b1; op = OP_AUIPC; imm = imm_u; arg2_src = ARG_SRC_IMM;
      end
      7'b1101111: begin
        legal = 1'b1; has_rd = 1'b1; op = OP_JAL; op_unit = OP_UNIT_BRU;
        sub_op.bru_op = BRU_JAL; imm = imm_j;
      end
      7'b1100111: begin
        legal = (funct3 == 3'b000); has_rd = 1'b1; op = OP_JALR; op_unit = OP_UNIT_BRU;
        sub_op.bru_op = BRU_JALR; imm = imm_i; arg1_src = ARG_SRC_REG;
      end
      7'b1100011: begin
        legal = 1'b1; op_unit = OP_UNIT_BRU; imm = imm_b;
        arg1_src = ARG_SRC_REG; arg2_src = ARG_SRC_REG;
        case (funct3)
          3'b000:  begin op = OP_BEQ;  sub_op.bru_op = BRU_BEQ;  end
          3'b001:  begin op = OP_BNE;  sub_op.bru_op = BRU_BNE;  end
          3'b100:  begin op = OP_BLT;  sub_op.bru_op = BRU_BLT;  end
          3'b101:  begin op = OP_BGE;  sub_op.bru_op = BRU_BGE;  end
          3'b110:  begin op = OP_BLTU; sub_op.bru_op = BRU_BLTU; end
          3'b111:  begin op = OP_BGEU; sub_op.bru_op = BRU_BGEU; end
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        legal = 1'b1; has_rd = 1'b1; op_unit = OP_UNIT_LSU; imm = imm_i; arg1_src = ARG_SRC_REG;
        case (funct3)
          3'b000:  begin op = OP_LB;  sub_op.lsu_op = LSU_LB;  end
          3'b001:  begin op = OP_LH;  sub_op.lsu_op = LSU_LH;  end
          3'b010:  begin op = OP_LW;  sub_op.lsu_op = LSU_LW;  end
          3'b100:  begin op = OP_LBU; sub_op.lsu_op = LSU_LBU; end
          3'b101:  begin op = OP_LHU; sub_op.lsu_op = LSU_LHU; end
          default: legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        legal = 1'b1; op_unit = OP_UNIT_LSU; imm = imm_s;
        arg1_src = ARG_SRC_REG; arg2_src = ARG_SRC_REG;
        case (funct3)
          3'b000:  begin op = OP_SB; sub_op.lsu_op = LSU_SB; end
          3'b001:  begin op = OP_SH; sub_op.lsu_op = LSU_SH; end
          3'b010:  begin op = OP_SW; sub_op.lsu_op = LSU_SW; end
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        legal = 1'b1; has_rd = 1'b1; imm = imm_i; arg1_src = ARG_SRC_REG; arg2_src = ARG_SRC_IMM;
        case (funct3)
          3'b000: begin op = OP_ADDI;  sub_op.alu_op = ALU_ADD;  end
          3'b010: begin op = OP_SLTI;  sub_op.alu_op = ALU_SLT;  end
          3'b011: begin op = OP_SLTIU; sub_op.alu_op = ALU_SLTU; end
          3'b100: begin op = OP_XORI;  sub_op.alu_op = ALU_XOR;  end
          3'b110: begin op = OP_ORI;   sub_op.alu_op = ALU_OR;   end
          3'b111: begin op = OP_ANDI;  sub_op.alu_op = ALU_AND;  end
          3'b001: begin op = OP_SLLI;  sub_op.alu_op = ALU_SLL; legal = (funct7 == 7'b0000000); end
          default: begin
            if (funct7 == 7'b0000000) begin op = OP_SRLI; sub_op.alu_op = ALU_SRL; end
            else if (funct7 == 7'b0100000) begin op = OP_SRAI; sub_op.alu_op = ALU_SRA; end
            else legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        legal = 1'b1; has_rd = 1'b1; arg1_src = ARG_SRC_REG; arg2_src = ARG_SRC_REG;
        if (funct7 == 7'b0000001) begin
          op_unit = funct3[2] ? OP_UNIT_DIV : OP_UNIT_MUL;
          case (funct3)
            3'b000:  begin op = OP_MUL;    sub_op.mul_op = MUL_MUL;    end
            3'b001:  begin op = OP_MULH;   sub_op.mul_op = MUL_MULH;   end
            3'b010:  begin op = OP_MULHSU; sub_op.mul_op = MUL_MULHSU; end
            3'b011:  begin op = OP_MULHU;  sub_op.mul_op = MUL_MULHU;  end
            3'b100:  begin op = OP_DIV;    sub_op.div_op = DIV_DIV;    end
            3'b101:  begin op = OP_DIVU;   sub_op.div_op = DIV_DIVU;   end
            3'b110:  begin op = OP_REM;    sub_op.div_op = DIV_REM;    end
            default: begin op = OP_REMU;   sub_op.div_op = DIV_REMU;   end
          endcase
        end else if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin op = OP_ADD;  sub_op.alu_op = ALU_ADD;  end
            3'b001:  begin op = OP_SLL;  sub_op.alu_op = ALU_SLL;  end
            3'b010:  begin op = OP_SLT;  sub_op.alu_op = ALU_SLT;  end
            3'b011:  begin op = OP_SLTU; sub_op.alu_op = ALU_SLTU; end
            3'b100:  begin op = OP_XOR;  sub_op.alu_op = ALU_XOR;  end
            3'b101:  begin op = OP_SRL;  sub_op.alu_op = ALU_SRL;  end
            3'b110:  begin op = OP_OR;   sub_op.alu_op = ALU_OR;   end
            default: begin op = OP_AND;  sub_op.alu_op = ALU_AND;  end
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          op = OP_SUB; sub_op.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          op = OP_SRA; sub_op.alu_op = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      7'b0001111: begin
        legal = (funct3 == 3'b000); op = OP_FENCE;
      end
      7'b1110011: begin
        op_unit = OP_UNIT_CSR;
        case (funct3)
          3'b000: begin
            legal = 1'b1;
            if (v == 32'h0000_0073)      begin op = OP_ECALL;  sub_op.csr_op = CSR_ECALL;  end
            else if (v == 32'h0010_0073) begin op = OP_EBREAK; sub_op.csr_op = CSR_EBREAK; end
            else if (v == 32'h3020_0073) begin op = OP_MRET;   sub_op.csr_op = CSR_MRET;   end
            else if (v == 32'h1050_0073) begin op = OP_WFI;    sub_op.csr_op = CSR_WFI;    end
            else legal = 1'b0;
          end
          3'b100: legal = 1'b0;
          default: begin
            legal = 1'b1; has_rd = 1'b1;
            arg1_src = funct3[2] ? ARG_SRC_IMM : ARG_SRC_REG;
            imm      = funct3[2] ? imm_z : 32'h0;
            case (funct3)
              3'b001:  begin op = OP_CSRRW;  sub_op.csr_op = CSR_RW; end
              3'b010:  begin op = OP_CSRRS;  sub_op.csr_op = CSR_RS; end
              3'b011:  begin op = OP_CSRRC;  sub_op.csr_op = CSR_RC; end
              3'b101:  begin op = OP_CSRRWI; sub_op.csr_op = CSR_RW; end
              3'b110:  begin op = OP_CSRRSI; sub_op.csr_op = CSR_RS; end
              default: begin op = OP_CSRRCI; sub_op.csr_op = CSR_RC; end
            endcase
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dr_out           = '0;
    dr_out.value     = v;
    dr_out.pc        = fd_in.pc;
    dr_out.op        = op;
    dr_out.op_unit   = op_unit;
    dr_out.sub_op    = sub_op;
    dr_out.imm       = imm;
    dr_out.arg1_src  = arg1_src;
    dr_out.arg2_src  = arg2_src;
    dr_out.rs1       = v[19:15];
    dr_out.rs2       = v[24:20];
    dr_out.rd        = v[11:7];
    dr_out.rd_enable = legal && has_rd && (v[11:7] != 5'd0);
    dr_out.csr       = v[31:20];
    // a fetch-side fault takes priority over anything the decoder finds
    if (fd_in.has_exception) begin
      dr_out.has_exception   = 1'b1;
      dr_out.exception_id    = fd_in.exception_id;
      dr_out.exception_value = fd_in.exception_value;
    end else if (!legal) begin
      dr_out.has_exception   = 1'b1;
      dr_out.exception_id    = EXC_ILLEGAL_INSTRUCTION;
      dr_out.exception_value = v;
    end
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage top: in-order accept chain between fetch and rename FIFOs,
// commit flush, idle feedback and rename-full performance event.
module decode_unit
  import decode_unit_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst,
  input  fetch_decode_pack_t  [DECODE_WIDTH-1:0]  fetch_decode_fifo_data_out,
  input  logic                [DECODE_WIDTH-1:0]  fetch_decode_fifo_data_out_valid,
  output logic                [DECODE_WIDTH-1:0]  fetch_decode_fifo_data_pop_valid,
  output logic                                    fetch_decode_fifo_pop,
  input  logic                [DECODE_WIDTH-1:0]  decode_rename_fifo_data_in_enable,
  output decode_rename_pack_t [DECODE_WIDTH-1:0]  decode_rename_fifo_data_in,
  output logic                [DECODE_WIDTH-1:0]  decode_rename_fifo_data_in_valid,
  output logic                                    decode_rename_fifo_push,
  output logic                                    decode_rename_fifo_flush,
  output decode_feedback_pack_t                   decode_feedback_pack,
  input  commit_feedback_pack_t                   commit_feedback_pack,
  output logic                                    decode_csrf_decode_rename_fifo_full_add
);

  logic [DECODE_WIDTH-1:0] accept;
  logic                    chain;
  logic                    flush;
  logic                    unused_ok;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_dec
    decode_one u_decode_one (
      .fd_in  (fetch_decode_fifo_data_out[g]),
      .dr_out (decode_rename_fifo_data_in[g])
    );
  end

  // the first slot that is invalid or lacks space blocks all younger slots
  always_comb begin
    accept = '0;
    chain  = 1'b1;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      chain     = chain & fetch_decode_fifo_data_out_valid[i] & decode_rename_fifo_data_in_enable[i];
      accept[i] = chain;
    end
  end

  assign flush = rst && commit_feedback_pack.enable && commit_feedback_pack.flush;

  always_comb begin
    fetch_decode_fifo_data_pop_valid = (rst && !flush) ? accept : '0;
    decode_rename_fifo_data_in_valid = (rst && !flush) ? accept : '0;
    fetch_decode_fifo_pop            = rst;
    decode_rename_fifo_push          = rst;
    decode_rename_fifo_flush         = flush;
    decode_feedback_pack             = '0;
    decode_feedback_pack.idle        = !rst || (fetch_decode_fifo_data_out_valid == '0);
    decode_csrf_decode_rename_fifo_full_add = rst && fetch_decode_fifo_data_out_valid[0] &&
                                              !decode_rename_fifo_data_in_enable[0] && !flush;
  end

  assign unused_ok = ^{clk, commit_feedback_pack.committed_num};

endmodule

// File: tb/tb_decode_unit.sv
// Directed self-checking bench for decode_unit.
module tb_decode_unit;
  import decode_unit_pkg::*;

  logic clk;
  logic rst;
  fetch_decode_pack_t  [DECODE_WIDTH-1:0] fd;
  logic                [DECODE_WIDTH-1:0] fd_valid;
  logic                [DECODE_WIDTH-1:0] pop_valid;
  logic                                   pop;
  logic                [DECODE_WIDTH-1:0] dr_enable;
  decode_rename_pack_t [DECODE_WIDTH-1:0] dr;
  logic                [DECODE_WIDTH-1:0] dr_valid;
  logic                                   push;
  logic                                   flush;
  decode_feedback_pack_t                  fb;
  commit_feedback_pack_t                  cfb;
  logic                                   full_add;

  int checks;
  int failures;

  typedef struct packed {
    logic [31:0] val;
    op_t         op;
    op_unit_t    unit;
    logic [31:0] imm;
    logic        rd_en;
    arg_src_t    a1;
    arg_src_t    a2;
  } vec_t;

  vec_t vecs [12];

  decode_unit dut (
    .clk                                    (clk),
    .rst                                    (rst),
    .fetch_decode_fifo_data_out             (fd),
    .fetch_decode_fifo_data_out_valid       (fd_valid),
    .fetch_decode_fifo_data_pop_valid       (pop_valid),
    .fetch_decode_fifo_pop                  (pop),
    .decode_rename_fifo_data_in_enable      (dr_enable),
    .decode_rename_fifo_data_in             (dr),
    .decode_rename_fifo_data_in_valid       (dr_valid),
    .decode_rename_fifo_push                (push),
    .decode_rename_fifo_flush               (flush),
    .decode_feedback_pack                   (fb),
    .commit_feedback_pack                   (cfb),
    .decode_csrf_decode_rename_fifo_full_add(full_add)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_all(input logic [31:0] val);
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      fd[i]       = '0;
      fd[i].value = val;
      fd[i].pc    = 32'h1000 + 32'(i * 4);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load_all(32'hf8410113); fd_valid = '1; dr_enable = '1;
    cfb = '0;
    settle();
    checks++; if (pop_valid !== 4'b0000) begin failures++; $display("FAIL rst_pop_valid got=%b exp=0000", pop_valid); end
    checks++; if (dr_valid !== 4'b0000) begin failures++; $display("FAIL rst_data_in_valid got=%b exp=0000", dr_valid); end
    checks++; if ({pop, push, flush} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {pop, push, flush}); end
    checks++; if (fb.idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", fb.idle); end
    dr_enable = '0;
    settle();
    checks++; if (full_add !== 1'b0) begin failures++; $display("FAIL rst_full_add got=%b exp=0", full_add); end
  endtask

  task automatic test_idle();
    rst = 1'b1; fd_valid = '0; dr_enable = '1;
    settle();
    checks++; if ({pop, push, flush} !== 3'b110) begin failures++; $display("FAIL idle_strobes got=%b exp=110", {pop, push, flush}); end
    checks++; if ({pop_valid, dr_valid} !== 8'h00) begin failures++; $display("FAIL idle_valids got=%h exp=00", {pop_valid, dr_valid}); end
    checks++; if ({fb.idle, full_add} !== 2'b10) begin failures++; $display("FAIL idle_fb got=%b exp=10", {fb.idle, full_add}); end
    dr_enable = '0;
    settle();
    checks++; if (full_add !== 1'b0) begin failures++; $display("FAIL idle_full_add_noinput got=%b exp=0", full_add); end
  endtask

  task automatic test_addi();
    load_all(32'hf8410113); fd_valid = '1; dr_enable = '1;
    settle();
    checks++; if (pop_valid !== 4'b1111) begin failures++; $display("FAIL addi_pop_valid got=%b exp=1111", pop_valid); end
    checks++; if (dr_valid !== 4'b1111) begin failures++; $display("FAIL addi_data_in_valid got=%b exp=1111", dr_valid); end
    checks++; if (fb.idle !== 1'b0) begin failures++; $display("FAIL addi_idle got=%b exp=0", fb.idle); end
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      checks++;
      if (dr[i].op !== OP_ADDI || dr[i].op_unit !== OP_UNIT_ALU || dr[i].sub_op.alu_op !== ALU_ADD) begin
        failures++; $display("FAIL addi_op slot=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
          dr[i].op, dr[i].op_unit, dr[i].sub_op.alu_op, OP_ADDI, OP_UNIT_ALU, ALU_ADD);
      end
      checks++;
      if (dr[i].imm !== 32'hffffff84 || dr[i].arg1_src !== ARG_SRC_REG || dr[i].arg2_src !== ARG_SRC_IMM) begin
        failures++; $display("FAIL addi_imm_args slot=%0d got=%h/%0d/%0d exp=ffffff84/%0d/%0d", i,
          dr[i].imm, dr[i].arg1_src, dr[i].arg2_src, ARG_SRC_REG, ARG_SRC_IMM);
      end
      checks++;
      if ({dr[i].rs1, dr[i].rd, dr[i].rd_enable, dr[i].has_exception} !== {5'd2, 5'd2, 1'b1, 1'b0}) begin
        failures++; $display("FAIL addi_regs slot=%0d got=%h exp=%h", i,
          {dr[i].rs1, dr[i].rd, dr[i].rd_enable, dr[i].has_exception}, {5'd2, 5'd2, 1'b1, 1'b0});
      end
      checks++;
      if (dr[i].pc !== 32'h1000 + 32'(i * 4) || dr[i].value !== 32'hf8410113) begin
        failures++; $display("FAIL addi_passthru slot=%0d got=%h/%h exp=%h/f8410113", i,
          dr[i].pc, dr[i].value, 32'h1000 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_flush();
    cfb.enable = 1'b1; cfb.flush = 1'b1;
    settle();
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL flush_out got=%b exp=1", flush); end
    checks++; if ({pop_valid, dr_valid} !== 8'h00) begin failures++; $display("FAIL flush_valids got=%h exp=00", {pop_valid, dr_valid}); end
    dr_enable = '0;
    settle();
    checks++; if (full_add !== 1'b0) begin failures++; $display("FAIL flush_full_add got=%b exp=0", full_add); end
    cfb.enable = 1'b0; dr_enable = '1;
    settle();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL flush_needs_enable got=%b exp=0", flush); end
    checks++; if (pop_valid !== 4'b1111) begin failures++; $display("FAIL flush_released got=%b exp=1111", pop_valid); end
    cfb = '0;
  endtask

  task automatic test_partial();
    fd_valid = '1; dr_enable = 4'b0011;
    settle();
    checks++; if ({pop_valid, dr_valid} !== 8'h33) begin failures++; $display("FAIL partial_0011 got=%h exp=33", {pop_valid, dr_valid}); end
    dr_enable = 4'b1101;
    settle();
    checks++; if (pop_valid !== 4'b0001) begin failures++; $display("FAIL partial_gap_space got=%b exp=0001", pop_valid); end
    fd_valid = 4'b1011; dr_enable = 4'b1111;
    settle();
    checks++; if (dr_valid !== 4'b0011) begin failures++; $display("FAIL partial_gap_valid got=%b exp=0011", dr_valid); end
    fd_valid = 4'b1111; dr_enable = 4'b0000;
    settle();
    checks++; if ({pop_valid, full_add} !== 5'b00001) begin failures++; $display("FAIL partial_full got=%b exp=00001", {pop_valid, full_add}); end
    fd_valid = 4'b1110;
    settle();
    checks++; if ({full_add, fb.idle} !== 2'b00) begin failures++; $display("FAIL partial_slot0_empty got=%b exp=00", {full_add, fb.idle}); end
  endtask

  task automatic test_decode_misc();
    vecs[0]  = '{32'h123452b7, OP_LUI,    OP_UNIT_ALU, 32'h12345000, 1'b1, ARG_SRC_DISABLE, ARG_SRC_IMM};
    vecs[1]  = '{32'h00208463, OP_BEQ,    OP_UNIT_BRU, 32'h00000008, 1'b0, ARG_SRC_REG,     ARG_SRC_REG};
    vecs[2]  = '{32'h00322623, OP_SW,     OP_UNIT_LSU, 32'h0000000c, 1'b0, ARG_SRC_REG,     ARG_SRC_REG};
    vecs[3]  = '{32'h02c58533, OP_MUL,    OP_UNIT_MUL, 32'h00000000, 1'b1, ARG_SRC_REG,     ARG_SRC_REG};
    vecs[4]  = '{32'h300110f3, OP_CSRRW,  OP_UNIT_CSR, 32'h00000000, 1'b1, ARG_SRC_REG,     ARG_SRC_DISABLE};
    vecs[5]  = '{32'hfe001ee3, OP_BNE,    OP_UNIT_BRU, 32'hfffffffc, 1'b0, ARG_SRC_REG,     ARG_SRC_REG};
    vecs[6]  = '{32'h0100006f, OP_JAL,    OP_UNIT_BRU, 32'h00000010, 1'b0, ARG_SRC_DISABLE, ARG_SRC_DISABLE};
    vecs[7]  = '{32'h00000073, OP_ECALL,  OP_UNIT_CSR, 32'h00000000, 1'b0, ARG_SRC_DISABLE, ARG_SRC_DISABLE};
    vecs[8]  = '{32'hff832383, OP_LW,     OP_UNIT_LSU, 32'hfffffff8, 1'b1, ARG_SRC_REG,     ARG_SRC_DISABLE};
    vecs[9]  = '{32'h4030d093, OP_SRAI,   OP_UNIT_ALU, 32'h00000403, 1'b1, ARG_SRC_REG,     ARG_SRC_IMM};
    vecs[10] = '{32'h025271b3, OP_REMU,   OP_UNIT_DIV, 32'h00000000, 1'b1, ARG_SRC_REG,     ARG_SRC_REG};
    vecs[11] = '{32'h3412d273, OP_CSRRWI, OP_UNIT_CSR, 32'h00000005, 1'b1, ARG_SRC_IMM,     ARG_SRC_DISABLE};
    fd_valid = '1; dr_enable = '1;
    for (int g = 0; g < 3; g++) begin
      for (int s = 0; s < DECODE_WIDTH; s++) begin
        fd[s]       = '0;
        fd[s].value = vecs[g * 4 + s].val;
      end
      settle();
      for (int s = 0; s < DECODE_WIDTH; s++) begin
        checks++;
        if (dr[s].op !== vecs[g*4+s].op || dr[s].op_unit !== vecs[g*4+s].unit || dr[s].imm !== vecs[g*4+s].imm ||
            dr[s].rd_enable !== vecs[g*4+s].rd_en || dr[s].arg1_src !== vecs[g*4+s].a1 ||
            dr[s].arg2_src !== vecs[g*4+s].a2 || dr[s].has_exception !== 1'b0) begin
          failures++;
          $display("FAIL decode_%h got op=%0d unit=%0d imm=%h rden=%b a1=%0d a2=%0d exc=%b exp op=%0d unit=%0d imm=%h rden=%b a1=%0d a2=%0d exc=0",
            vecs[g*4+s].val, dr[s].op, dr[s].op_unit, dr[s].imm, dr[s].rd_enable, dr[s].arg1_src, dr[s].arg2_src,
            dr[s].has_exception, vecs[g*4+s].op, vecs[g*4+s].unit, vecs[g*4+s].imm, vecs[g*4+s].rd_en,
            vecs[g*4+s].a1, vecs[g*4+s].a2);
        end
      end
      if (g == 1) begin
        checks++;
        if (dr[0].csr !== 12'h300 || dr[0].rs1 !== 5'd2 || dr[0].rd !== 5'd1) begin
          failures++; $display("FAIL decode_csr_fields got=%h/%0d/%0d exp=300/2/1", dr[0].csr, dr[0].rs1, dr[0].rd);
        end
      end
    end
  endtask

  task automatic test_illegal();
    load_all(32'hf8410113);
    fd[0].value           = 32'hffffffff;
    fd[1].has_exception   = 1'b1;
    fd[1].exception_id    = EXC_INSTR_ACCESS_FAULT;
    fd[1].exception_value = 32'h00001234;
    fd[2].value           = 32'h40209133;
    fd_valid = '1; dr_enable = '1;
    settle();
    checks++;
    if (dr[0].has_exception !== 1'b1 || dr[0].exception_id !== EXC_ILLEGAL_INSTRUCTION ||
        dr[0].exception_value !== 32'hffffffff || dr[0].rd_enable !== 1'b0) begin
      failures++; $display("FAIL illegal_all_ones got=%b/%0d/%h/%b exp=1/%0d/ffffffff/0", dr[0].has_exception,
        dr[0].exception_id, dr[0].exception_value, dr[0].rd_enable, EXC_ILLEGAL_INSTRUCTION);
    end
    checks++;
    if (dr[1].has_exception !== 1'b1 || dr[1].exception_id !== EXC_INSTR_ACCESS_FAULT ||
        dr[1].exception_value !== 32'h00001234) begin
      failures++; $display("FAIL exc_passthru got=%b/%0d/%h exp=1/%0d/00001234", dr[1].has_exception,
        dr[1].exception_id, dr[1].exception_value, EXC_INSTR_ACCESS_FAULT);
    end
    checks++;
    if (dr[2].has_exception !== 1'b1 || dr[2].exception_value !== 32'h40209133 || dr[2].rd_enable !== 1'b0) begin
      failures++; $display("FAIL illegal_funct7 got=%b/%h/%b exp=1/40209133/0", dr[2].has_exception,
        dr[2].exception_value, dr[2].rd_enable);
    end
    checks++; if (dr[3].has_exception !== 1'b0) begin failures++; $display("FAIL legal_no_exc got=%b exp=0", dr[3].has_exception); end
    checks++; if (pop_valid !== 4'b1111) begin failures++; $display("FAIL illegal_still_accepted got=%b exp=1111", pop_valid); end
  endtask

  task automatic test_rst_mid();
    load_all(32'hf8410113); fd_valid = '1; dr_enable = '1;
    settle();
    checks++; if (dr_valid !== 4'b1111) begin failures++; $display("FAIL rstmid_before got=%b exp=1111", dr_valid); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({pop_valid, dr_valid} !== 8'h00) begin failures++; $display("FAIL rstmid_valids got=%h exp=00", {pop_valid, dr_valid}); end
    checks++; if ({fb.idle, pop, push} !== 3'b100) begin failures++; $display("FAIL rstmid_idle_strobes got=%b exp=100", {fb.idle, pop, push}); end
    rst = 1'b1;
    settle();
    checks++; if (pop_valid !== 4'b1111) begin failures++; $display("FAIL rstmid_release got=%b exp=1111", pop_valid); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; fd = '0; fd_valid = '0; dr_enable = '0; cfb = '0;
    test_reset();
    test_idle();
    test_addi();
    test_flush();
    test_partial();
    test_decode_misc();
    test_illegal();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
